// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with occupancy count, threshold flags and sticky error flags
module param_sync_fifo #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     clr_err,
  input  logic [WIDTH-1:0]         in,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             rd_ok, wr_ok;
  // A read frees a slot in the same edge, so a full FIFO can still take a write alongside it
  always_comb begin
    full         = count == FULL_C;
    empty        = count == '0;
    almost_full  = count >= AF_C;
    almost_empty = count <= AE_C;
    rd_ok        = en & rd_en & ~empty;
    wr_ok        = en & wr_en & (~full | rd_ok);
  end
  // Storage array is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= in;
  end
  // Pointers, occupancy, registered read data and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      out       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (en) begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
        out  <= mem[rptr];
      end
      if (wr_ok != rd_ok) count <= wr_ok ? count + 1'b1 : count - 1'b1;
      overflow  <= (wr_en & ~wr_ok) | (overflow & ~clr_err);
      underflow <= (rd_en & ~rd_ok) | (underflow & ~clr_err);
    end
  end
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed vector table plus hand sequences for param_sync_fifo
module tb_param_sync_fifo;
  logic       tb_clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [3:0] in = '0;
  logic [3:0] out;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  int         n_vec = 0;
  int         n_err = 0;

  typedef struct {
    logic       r, e, w, rd, c;
    logic [3:0] d;
    logic [3:0] cnt, o;
    logic       ov, un;
  } vec_t;
  vec_t v[$];

  param_sync_fifo #(.WIDTH(4), .DEPTH(8)) dut (
    .clk(tb_clk), .rst(rst), .en(en), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .in(in), .out(out), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 tb_clk = ~tb_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "timeout");
  end

  function automatic void add(logic r, logic e, logic w, logic rd, logic c, logic [3:0] d,
                              logic [3:0] cnt, logic [3:0] o, logic ov, logic un);
    vec_t x;
    x.r = r; x.e = e; x.w = w; x.rd = rd; x.c = c; x.d = d;
    x.cnt = cnt; x.o = o; x.ov = ov; x.un = un;
    v.push_back(x);
  endfunction

  function automatic void cmp(string tag, string name, int act, int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s %s: got %0d, expected %0d", tag, name, act, exp);
    end
  endfunction

  task automatic check(string tag, logic [3:0] cnt, logic [3:0] o, logic ov, logic un);
    n_vec++;
    cmp(tag, "count", int'(count), int'(cnt));
    cmp(tag, "out", int'(out), int'(o));
    cmp(tag, "full", int'(full), int'(cnt == 4'd8));
    cmp(tag, "empty", int'(empty), int'(cnt == 4'd0));
    cmp(tag, "almost_full", int'(almost_full), int'(cnt >= 4'd7));
    cmp(tag, "almost_empty", int'(almost_empty), int'(cnt <= 4'd1));
    cmp(tag, "overflow", int'(overflow), int'(ov));
    cmp(tag, "underflow", int'(underflow), int'(un));
  endtask

  task automatic step(string tag, logic r, logic e, logic w, logic rd, logic c, logic [3:0] d,
                      logic [3:0] cnt, logic [3:0] o, logic ov, logic un);
    @(negedge tb_clk);
    rst = r; en = e; wr_en = w; rd_en = rd; clr_err = c; in = d;
    @(posedge tb_clk);
    #1;
    check(tag, cnt, o, ov, un);
  endtask

  initial begin
    // reset
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // fill 0..7
    for (int i = 0; i < 8; i++) add(1, 1, 1, 0, 0, 4'(i), 4'(i + 1), 0, 0, 0);
    // overflow attempt with 4'hA
    add(1, 1, 1, 0, 0, 4'hA, 8, 0, 1, 0);
    // drain 0..7, overflow stays sticky
    for (int k = 0; k < 8; k++) add(1, 1, 0, 1, 0, 0, 4'(7 - k), 4'(k), 1, 0);
    add(1, 1, 0, 0, 1, 0, 0, 7, 0, 0);
    // simultaneous at empty: write taken, read rejected
    add(1, 1, 1, 1, 0, 9, 1, 7, 0, 1);
    add(1, 1, 0, 0, 1, 0, 1, 7, 0, 0);
    // refill to 8 with 9,1..7
    for (int i = 1; i < 8; i++) add(1, 1, 1, 0, 0, 4'(i), 4'(i + 1), 7, 0, 0);
    // simultaneous at full: both taken
    add(1, 1, 1, 1, 0, 3, 8, 9, 0, 0);
    // drain 1..7,3
    for (int k = 0; k < 8; k++) add(1, 1, 0, 1, 0, 0, 4'(7 - k), (k < 7) ? 4'(k + 1) : 4'd3, 0, 0);
    // underflow set wins over clr_err in the same cycle
    add(1, 1, 0, 1, 1, 0, 0, 3, 0, 1);
    add(1, 1, 0, 0, 1, 0, 0, 3, 0, 0);
    // en=0 freezes: no read, no flag
    add(1, 0, 1, 1, 0, 5, 0, 3, 0, 0);

    for (int i = 0; i < v.size(); i++)
      step($sformatf("vec%0d", i), v[i].r, v[i].e, v[i].w, v[i].rd, v[i].c, v[i].d,
           v[i].cnt, v[i].o, v[i].ov, v[i].un);

    // wrap: pointers sit at offset 1, 12 overlapped write/read pairs cross the end
    step("wrap_w0", 1, 1, 1, 0, 0, 0, 1, 3, 0, 0);
    for (int i = 1; i <= 12; i++)
      step($sformatf("wrap%0d", i), 1, 1, 1, 1, 0, 4'(i), 1, 4'(i - 1), 0, 0);
    step("wrap_rd", 1, 1, 0, 1, 0, 0, 0, 12, 0, 0);

    // fill, then en=0 with wr_en must not count or flag
    for (int i = 0; i < 8; i++) step($sformatf("fill%0d", i), 1, 1, 1, 0, 0, 4'(i), 4'(i + 1), 12, 0, 0);
    step("en0_wr", 1, 0, 1, 0, 0, 4'hF, 8, 12, 0, 0);
    step("en0_wr2", 1, 0, 1, 0, 0, 4'hE, 8, 12, 0, 0);

    // drain to 5, then reset mid-stream
    for (int k = 0; k < 3; k++) step($sformatf("pre%0d", k), 1, 1, 0, 1, 0, 0, 4'(7 - k), 4'(k), 0, 0);
    @(negedge tb_clk);
    rst = 1'b0; en = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    #1;
    check("async_rst", 0, 0, 0, 0);
    step("post_rst_wr", 1, 1, 1, 0, 0, 4'hC, 1, 0, 0, 0);
    step("post_rst_rd", 1, 1, 0, 1, 0, 0, 0, 4'hC, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
